// File: rtl/pzcorebus_pkg.sv
// pzcorebus_pkg: shared width helpers for the corebus response order controller
package pzcorebus_pkg;
  function automatic int calc_port_width(input int masters);
    return (masters > 1) ? $clog2(masters) : 1;
  endfunction
  function automatic int calc_count_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction
endpackage

// File: rtl/pzcorebus_response_order_queue.sv
// pzcorebus_response_order_queue: synchronous-reset FIFO of destination port indices
module pzcorebus_response_order_queue
  import pzcorebus_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int WIDTH       = 1,
  parameter int COUNT_WIDTH = calc_count_width(DEPTH)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       data,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [COUNT_WIDTH-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign head  = mem[rp];
  assign full  = count == COUNT_WIDTH'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= data;
  always_ff @(posedge clk)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= inc(wp);
      if (pop) rp <= inc(rp);
      count <= count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
    end
endmodule

// File: rtl/pzcorebus_response_order_controller.sv
// pzcorebus_response_order_controller: grants the response path to masters in request issue order
module pzcorebus_response_order_controller
  import pzcorebus_pkg::*;
#(
  parameter int MASTERS         = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int PORT_WIDTH      = calc_port_width(MASTERS),
  parameter int COUNT_WIDTH     = calc_count_width(MAX_OUTSTANDING)
)(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_request_valid,
  input  logic [PORT_WIDTH-1:0]  i_request_port,
  output logic                   o_request_ready,
  input  logic [MASTERS-1:0]     i_response_valid,
  input  logic [MASTERS-1:0]     i_response_last,
  input  logic                   i_response_ready,
  output logic [MASTERS-1:0]     o_response_grant,
  output logic [COUNT_WIDTH-1:0] o_outstanding,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_error
);
  logic                   port_ok;
  logic                   push;
  logic                   pop;
  logic                   handshake;
  logic [PORT_WIDTH-1:0]  head;
  logic [MASTERS-1:0]     zero;
  logic [COUNT_WIDTH-1:0] cnt [MASTERS];
  assign port_ok          = {1'b0, i_request_port} < (PORT_WIDTH + 1)'(MASTERS);
  assign o_request_ready  = !o_full;
  assign push             = i_request_valid && o_request_ready && port_ok;
  assign o_response_grant = o_empty ? '0 : MASTERS'(1) << head;
  assign handshake        = |(i_response_valid & o_response_grant) && i_response_ready;
  assign pop              = handshake && |(i_response_last & o_response_grant);
  pzcorebus_response_order_queue #(
    .DEPTH       (MAX_OUTSTANDING),
    .WIDTH       (PORT_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_queue (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .data  (i_request_port),
    .head  (head),
    .full  (o_full),
    .empty (o_empty),
    .count (o_outstanding)
  );
  always_comb begin
    zero = '0;
    for (int k = 0; k < MASTERS; k++) zero[k] = cnt[k] == '0;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_error <= 1'b0;
      for (int k = 0; k < MASTERS; k++) cnt[k] <= '0;
    end else begin
      o_error <= o_error || (i_request_valid && !port_ok) || |(i_response_valid & zero);
      for (int k = 0; k < MASTERS; k++)
        cnt[k] <= cnt[k] + COUNT_WIDTH'(push && i_request_port == PORT_WIDTH'(k))
                         - COUNT_WIDTH'(pop && head == PORT_WIDTH'(k));
    end
endmodule

// File: tb/tb_pzcorebus_response_order_controller.sv
// tb_pzcorebus_response_order_controller: directed tests on a 2x8 and a 3x3 controller
module tb_pzcorebus_response_order_controller;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  logic       a_req_valid, a_req_ready, a_rr, a_empty, a_full, a_err;
  logic [0:0] a_req_port;
  logic [1:0] a_rv, a_rl, a_grant;
  logic [3:0] a_out;
  logic       b_req_valid, b_req_ready, b_rr, b_empty, b_full, b_err;
  logic [1:0] b_req_port, b_out;
  logic [2:0] b_rv, b_rl, b_grant;
  pzcorebus_response_order_controller dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_request_valid(a_req_valid), .i_request_port(a_req_port), .o_request_ready(a_req_ready),
    .i_response_valid(a_rv), .i_response_last(a_rl), .i_response_ready(a_rr),
    .o_response_grant(a_grant), .o_outstanding(a_out), .o_empty(a_empty), .o_full(a_full), .o_error(a_err)
  );
  pzcorebus_response_order_controller #(.MASTERS(3), .MAX_OUTSTANDING(3)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_request_valid(b_req_valid), .i_request_port(b_req_port), .o_request_ready(b_req_ready),
    .i_response_valid(b_rv), .i_response_last(b_rl), .i_response_ready(b_rr),
    .o_response_grant(b_grant), .o_outstanding(b_out), .o_empty(b_empty), .o_full(b_full), .o_error(b_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    {a_req_valid, a_req_port, a_rv, a_rl, a_rr} = '0;
    {b_req_valid, b_req_port, b_rv, b_rl, b_rr} = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({a_grant, a_out, a_empty, a_full, a_req_ready, a_err} !== {2'b00, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: got %b %0d %b %b %b %b", a_grant, a_out, a_empty, a_full, a_req_ready, a_err);
    end
    checks++;
    if ({b_grant, b_out, b_empty, b_full, b_req_ready, b_err} !== {3'b000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_b: got %b %0d %b %b %b %b", b_grant, b_out, b_empty, b_full, b_req_ready, b_err);
    end
    tick();
    a_req_valid = 1'b1;
    a_req_port  = 1'b1;
    tick();
    a_req_valid = 1'b0;
    checks++;
    if ({a_grant, a_out, a_empty} !== {2'b10, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL first_push: got grant=%b out=%0d empty=%b want 10 1 0", a_grant, a_out, a_empty);
    end
    a_rv = 2'b10;
    a_rl = 2'b10;
    a_rr = 1'b1;
    tick();
    a_rv = '0;
    checks++;
    if ({a_grant, a_out, a_empty, a_err} !== {2'b00, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL first_pop: got grant=%b out=%0d empty=%b err=%b", a_grant, a_out, a_empty, a_err);
    end
  endtask
  task automatic test_order();
    a_req_valid = 1'b1;
    a_req_port  = 1'b0;
    tick();
    a_req_port = 1'b1;
    tick();
    a_req_port = 1'b0;
    tick();
    a_req_valid = 1'b0;
    a_rv = 2'b10;
    a_rl = 2'b10;
    a_rr = 1'b1;
    tick();
    checks++;
    if ({a_grant, a_out, a_err} !== {2'b01, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL order_holdoff: got grant=%b out=%0d err=%b want 01 3 0", a_grant, a_out, a_err);
    end
    a_rv = 2'b11;
    a_rl = 2'b11;
    tick();
    checks++;
    if ({a_grant, a_out} !== {2'b10, 4'd2}) begin
      errors++;
      $display("FAIL order_second: got grant=%b out=%0d want 10 2", a_grant, a_out);
    end
    tick();
    a_rv = 2'b01;
    a_rl = 2'b01;
    checks++;
    if ({a_grant, a_out} !== {2'b01, 4'd1}) begin
      errors++;
      $display("FAIL order_third: got grant=%b out=%0d want 01 1", a_grant, a_out);
    end
    tick();
    a_rv = '0;
    a_rl = '0;
    checks++;
    if ({a_grant, a_empty, a_err} !== {2'b00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL order_drain: got grant=%b empty=%b err=%b", a_grant, a_empty, a_err);
    end
  endtask
  task automatic test_burst();
    logic [5:0] pat = 6'b101101;
    a_req_valid = 1'b1;
    a_req_port  = 1'b0;
    tick();
    a_req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_rv = 2'b01;
      a_rr = pat[i];
      a_rl = (i == 5) ? 2'b01 : 2'b00;
      tick();
      checks++;
      if ({a_grant, a_out} !== ((i < 5) ? {2'b01, 4'd1} : {2'b00, 4'd0})) begin
        errors++;
        $display("FAIL burst_beat%0d: got grant=%b out=%0d", i, a_grant, a_out);
      end
    end
    a_rv = '0;
    a_rl = '0;
  endtask
  task automatic test_full_wrap();
    int exp[$];
    for (int i = 0; i < 3; i++) begin
      b_req_valid = 1'b1;
      b_req_port  = 2'(i);
      tick();
    end
    checks++;
    if ({b_full, b_req_ready, b_out, b_grant} !== {1'b1, 1'b0, 2'd3, 3'b001}) begin
      errors++;
      $display("FAIL full: got full=%b ready=%b out=%0d grant=%b", b_full, b_req_ready, b_out, b_grant);
    end
    tick();
    b_req_valid = 1'b0;
    checks++;
    if ({b_out, b_err} !== {2'd3, 1'b0}) begin
      errors++;
      $display("FAIL full_reject: got out=%0d err=%b want 3 0", b_out, b_err);
    end
    b_rv = 3'b001;
    b_rl = 3'b001;
    b_rr = 1'b1;
    tick();
    checks++;
    if ({b_out, b_full, b_grant} !== {2'd2, 1'b0, 3'b010}) begin
      errors++;
      $display("FAIL pop_from_full: got out=%0d full=%b grant=%b", b_out, b_full, b_grant);
    end
    b_req_valid = 1'b1;
    b_req_port  = 2'd0;
    b_rv = 3'b010;
    b_rl = 3'b010;
    tick();
    checks++;
    if ({b_out, b_grant} !== {2'd2, 3'b100}) begin
      errors++;
      $display("FAIL push_pop: got out=%0d grant=%b want 2 100", b_out, b_grant);
    end
    exp = '{2, 0};
    for (int i = 0; i < 10; i++) begin
      b_req_port = 2'(i % 3);
      b_rv = 3'b001 << exp[0];
      b_rl = b_rv;
      tick();
      void'(exp.pop_front());
      exp.push_back(i % 3);
      checks++;
      if ({b_out, b_grant} !== {2'd2, 3'b001 << exp[0]}) begin
        errors++;
        $display("FAIL wrap%0d: got out=%0d grant=%b want head %0d", i, b_out, b_grant, exp[0]);
      end
    end
    b_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_rv = 3'b001 << exp[0];
      b_rl = b_rv;
      tick();
      void'(exp.pop_front());
    end
    b_rv = '0;
    b_rl = '0;
    checks++;
    if ({b_empty, b_out, b_grant, b_err} !== {1'b1, 2'd0, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL wrap_drain: got empty=%b out=%0d grant=%b err=%b", b_empty, b_out, b_grant, b_err);
    end
  endtask
  task automatic test_error();
    b_req_valid = 1'b1;
    b_req_port  = 2'd3;
    tick();
    b_req_valid = 1'b0;
    checks++;
    if ({b_err, b_out, b_req_ready} !== {1'b1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL bad_port: got err=%b out=%0d ready=%b want 1 0 1", b_err, b_out, b_req_ready);
    end
    tick();
    tick();
    checks++;
    if (b_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got err=%b want 1", b_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (b_err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: got err=%b want 0", b_err);
    end
    b_rv = 3'b010;
    tick();
    b_rv = '0;
    checks++;
    if (b_err !== 1'b1) begin
      errors++;
      $display("FAIL zero_count_resp: got err=%b want 1", b_err);
    end
  endtask
  task automatic test_reset_mid_burst();
    a_req_valid = 1'b1;
    a_req_port  = 1'b0;
    tick();
    a_req_port = 1'b1;
    tick();
    a_req_valid = 1'b0;
    a_rv = 2'b01;
    a_rl = 2'b00;
    a_rr = 1'b1;
    tick();
    checks++;
    if ({a_grant, a_out} !== {2'b01, 4'd2}) begin
      errors++;
      $display("FAIL mid_burst: got grant=%b out=%0d want 01 2", a_grant, a_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_rv = '0;
    checks++;
    if ({a_grant, a_empty, a_out, a_err, b_err} !== {2'b00, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_burst: got grant=%b empty=%b out=%0d err=%b/%b", a_grant, a_empty, a_out, a_err, b_err);
    end
  endtask
  initial begin
    test_reset();
    test_order();
    test_burst();
    test_full_wrap();
    test_error();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
